// File: rtl/sobel_window_3x3_pkg.sv
// rtl/sobel_window_3x3_pkg.sv - shared constants for the Sobel 3x3 window slice
// Purpose: pixel width, default image geometry and the neighbour tap order.
//   Tap indices 0..7 = lu, lm, ld, mu, md, ru, rm, rd. This matches the
//   neighbour array order of the gradient-direction stage. The centre tap (mm)
//   is not part of that array.
// Ports: none (package).
package sobel_window_3x3_pkg;

  localparam int PIX_W          = 12;
  localparam int DEF_IMG_WIDTH  = 320;
  localparam int DEF_IMG_HEIGHT = 240;

  localparam int TAP_LU   = 0;
  localparam int TAP_LM   = 1;
  localparam int TAP_LD   = 2;
  localparam int TAP_MU   = 3;
  localparam int TAP_MD   = 4;
  localparam int TAP_RU   = 5;
  localparam int TAP_RM   = 6;
  localparam int TAP_RD   = 7;
  localparam int NUM_TAPS = 8;

endpackage

// File: rtl/sobel_window_3x3_if.sv
// rtl/sobel_window_3x3_if.sv - pixel-in / window-out bundle of the Sobel window
// Purpose: groups the raster pixel input and the 3x3 window output.
// Ports:
//   in_valid, in_sof, in_pixel      : raster pixel stream into the window block
//   out_valid, out_sof, out_border  : window strobe, first-of-frame, incomplete
//   out_x, out_y                    : coordinate of the newest (rd) pixel
//   out_pixel_{l,m,r}{u,m,d}        : 3x3 taps, columns x-2..x, rows y-2..y
//   modport master : stream source / window consumer
//   modport slave  : the window block itself
interface sobel_window_3x3_if #(
  parameter int PIX_W = sobel_window_3x3_pkg::PIX_W,
  parameter int X_W   = $clog2(sobel_window_3x3_pkg::DEF_IMG_WIDTH),
  parameter int Y_W   = $clog2(sobel_window_3x3_pkg::DEF_IMG_HEIGHT)
);

  logic             in_valid;
  logic             in_sof;
  logic [PIX_W-1:0] in_pixel;

  logic             out_valid;
  logic             out_sof;
  logic             out_border;
  logic [X_W-1:0]   out_x;
  logic [Y_W-1:0]   out_y;
  logic [PIX_W-1:0] out_pixel_lu, out_pixel_lm, out_pixel_ld;
  logic [PIX_W-1:0] out_pixel_mu, out_pixel_mm, out_pixel_md;
  logic [PIX_W-1:0] out_pixel_ru, out_pixel_rm, out_pixel_rd;

  modport master (
    output in_valid, in_sof, in_pixel,
    input  out_valid, out_sof, out_border, out_x, out_y,
    input  out_pixel_lu, out_pixel_lm, out_pixel_ld,
    input  out_pixel_mu, out_pixel_mm, out_pixel_md,
    input  out_pixel_ru, out_pixel_rm, out_pixel_rd
  );

  modport slave (
    input  in_valid, in_sof, in_pixel,
    output out_valid, out_sof, out_border, out_x, out_y,
    output out_pixel_lu, out_pixel_lm, out_pixel_ld,
    output out_pixel_mu, out_pixel_mm, out_pixel_md,
    output out_pixel_ru, out_pixel_rm, out_pixel_rd
  );

endinterface

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - one image line of pixel storage
// Purpose: a RAM that is DEPTH entries deep and WIDTH bits wide. It has a synchronous read
//   and a write enable. When the read and write addresses match in the same
//   cycle, the read returns the old contents. The contents are not reset.
// Ports:
//   clk     : pixel clock
//   wrEn    : write enable
//   wrAddr  : write address
//   wrData  : write data
//   rdEn    : read enable; rdData holds its value while rdEn is low
//   rdAddr  : read address
//   rdData  : registered read data
module sobel_line_buffer #(
  parameter int DEPTH = sobel_window_3x3_pkg::DEF_IMG_WIDTH,
  parameter int WIDTH = sobel_window_3x3_pkg::PIX_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rdEn,
  input  logic [AW-1:0]    rdAddr,
  output logic [WIDTH-1:0] rdData
);
  import sobel_window_3x3_pkg::*;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rdEn) begin
      rdData <= mem[rdAddr];
    end
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

endmodule

// File: rtl/sobel_window_3x3.sv
// rtl/sobel_window_3x3.sv - raster stream to sliding 3x3 neighbourhood
// Purpose: builds the 3x3 window for the Sobel gradient stage.
//   - Frame coordinates are tracked from in_sof.
//   - Two line buffers supply rows y-1 and y-2.
//   - Column registers hold columns x-1 and x-2.
//   - Windows that reach outside the frame are flagged with out_border, and their taps are zeroed.
//   - Latency is a fixed 2 cycles.
// Ports:
//   clk   : pixel clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of sobel_window_3x3_if (pixel in, window out)
module sobel_window_3x3 #(
  parameter int IMG_WIDTH  = sobel_window_3x3_pkg::DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = sobel_window_3x3_pkg::DEF_IMG_HEIGHT,
  parameter int PIX_W      = sobel_window_3x3_pkg::PIX_W,
  parameter int X_W        = $clog2(IMG_WIDTH),
  parameter int Y_W        = $clog2(IMG_HEIGHT)
) (
  input logic              clk,
  input logic              rst_n,
  sobel_window_3x3_if.slave bus
);
  import sobel_window_3x3_pkg::*;

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

  // ---------------- stage 0: frame sync and coordinates ----------------
  logic             synced;
  logic [X_W-1:0]   xCnt;
  logic [Y_W-1:0]   yCnt;
  logic             startFrame;
  logic             accept;
  logic [X_W-1:0]   curX;
  logic [Y_W-1:0]   curY;

  // in_sof moves the current pixel to (0,0), wherever the counters are.
  assign startFrame = bus.in_valid && bus.in_sof;
  assign accept     = bus.in_valid && (synced || bus.in_sof);
  assign curX       = startFrame ? '0 : xCnt;
  assign curY       = startFrame ? '0 : yCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      synced <= 1'b0;
      xCnt   <= '0;
      yCnt   <= '0;
    end else if (accept) begin
      synced <= 1'b1;
      if (curX == X_LAST) begin
        xCnt <= '0;
        yCnt <= (curY == Y_LAST) ? '0 : curY + 1'b1;
      end else begin
        xCnt <= curX + 1'b1;
        yCnt <= curY;
      end
    end
  end

  // ---------------- stage 1: line-buffer access ----------------
  logic             s1Valid;
  logic             s1Sof;
  logic [X_W-1:0]   s1X;
  logic [Y_W-1:0]   s1Y;
  logic [PIX_W-1:0] s1Pix;
  logic [PIX_W-1:0] lb0Q;   // row y-1 at column x
  logic [PIX_W-1:0] lb1Q;   // row y-2 at column x

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid <= 1'b0;
      s1Sof   <= 1'b0;
      s1X     <= '0;
      s1Y     <= '0;
      s1Pix   <= '0;
    end else begin
      s1Valid <= accept;
      if (accept) begin
        s1Sof <= startFrame;
        s1X   <= curX;
        s1Y   <= curY;
        s1Pix <= bus.in_pixel;
      end
    end
  end

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(X_W)) lineBuf0 (
    .clk    (clk),
    .wrEn   (accept),
    .wrAddr (curX),
    .wrData (bus.in_pixel),
    .rdEn   (accept),
    .rdAddr (curX),
    .rdData (lb0Q)
  );

  // LB1 is written with the old LB0 word one cycle later, once the
  // synchronous read has produced it. The next pixel reads a different
  // column, so the delayed write cannot disturb it.
  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(X_W)) lineBuf1 (
    .clk    (clk),
    .wrEn   (s1Valid),
    .wrAddr (s1X),
    .wrData (lb0Q),
    .rdEn   (accept),
    .rdAddr (curX),
    .rdData (lb1Q)
  );

  // ---------------- stage 2: column shift, border, outputs ----------------
  logic [PIX_W-1:0] colMU, colMM, colMD;   // column x-1
  logic [PIX_W-1:0] colLU, colLM, colLD;   // column x-2
  logic [PIX_W-1:0] nbr [NUM_TAPS];
  logic             border;

  always_comb begin
    nbr[TAP_LU] = colLU;
    nbr[TAP_LM] = colLM;
    nbr[TAP_LD] = colLD;
    nbr[TAP_MU] = colMU;
    nbr[TAP_MD] = colMD;
    nbr[TAP_RU] = lb1Q;
    nbr[TAP_RM] = lb0Q;
    nbr[TAP_RD] = s1Pix;
  end

  assign border = (s1X < X_W'(2)) || (s1Y < Y_W'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colMU            <= '0;
      colMM            <= '0;
      colMD            <= '0;
      colLU            <= '0;
      colLM            <= '0;
      colLD            <= '0;
      bus.out_valid    <= 1'b0;
      bus.out_sof      <= 1'b0;
      bus.out_border   <= 1'b0;
      bus.out_x        <= '0;
      bus.out_y        <= '0;
      bus.out_pixel_lu <= '0;
      bus.out_pixel_lm <= '0;
      bus.out_pixel_ld <= '0;
      bus.out_pixel_mu <= '0;
      bus.out_pixel_mm <= '0;
      bus.out_pixel_md <= '0;
      bus.out_pixel_ru <= '0;
      bus.out_pixel_rm <= '0;
      bus.out_pixel_rd <= '0;
    end else begin
      bus.out_valid <= s1Valid;
      if (s1Valid) begin
        colLU <= colMU;
        colLM <= colMM;
        colLD <= colMD;
        colMU <= lb1Q;
        colMM <= lb0Q;
        colMD <= s1Pix;

        bus.out_sof      <= s1Sof;
        bus.out_border   <= border;
        bus.out_x        <= s1X;
        bus.out_y        <= s1Y;
        bus.out_pixel_lu <= border ? '0 : nbr[TAP_LU];
        bus.out_pixel_lm <= border ? '0 : nbr[TAP_LM];
        bus.out_pixel_ld <= border ? '0 : nbr[TAP_LD];
        bus.out_pixel_mu <= border ? '0 : nbr[TAP_MU];
        bus.out_pixel_mm <= border ? '0 : colMM;
        bus.out_pixel_md <= border ? '0 : nbr[TAP_MD];
        bus.out_pixel_ru <= border ? '0 : nbr[TAP_RU];
        bus.out_pixel_rm <= border ? '0 : nbr[TAP_RM];
        bus.out_pixel_rd <= border ? '0 : nbr[TAP_RD];
      end
    end
  end

endmodule
